// File: rtl/lcd_message_arbiter.sv
// Purpose: round-robin owner of the LCD message selector shared by access control (0), process control (1) and game (2).
// Latency: a request seen in IDLE is granted, acked and shown on lcd_char_array at the next clock edge.
// Backpressure: a granted code owns the LCD for HOLD_CYCLES cycles, then one IDLE cycle; pending requests simply wait (req held until ack).
//
// Ports:
//   clk, rst        - system clock; asynchronous active-high reset
//   req[2:0]        - level request per requester, held until its ack
//   req_msg[11:0]   - packed 4-bit codes, requester i at [4i+3:4i]
//   ack[2:0]        - one-cycle pulse to the winner in the cycle its code is first shown
//   lcd_char_array  - code driven to the LCD character-array select
//   busy            - high for the whole hold window
//   grant_id        - current owner 0..2, 3 when idle
//
// Parameters:
//   HOLD_CYCLES - cycles a granted code owns the LCD (must be >= 1)
//   DEFAULT_MSG - code shown after reset (and while idle when STICKY = 0)
//   STICKY      - 1 keeps the last granted code while idle, 0 reverts to DEFAULT_MSG

module lcd_message_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter logic [3:0]  DEFAULT_MSG = 4'd0,
    parameter bit          STICKY      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [11:0] req_msg,
    output logic [2:0]  ack,
    output logic [3:0]  lcd_char_array,
    output logic        busy,
    output logic [1:0]  grant_id
);

    // Counter is loaded with HOLD_CYCLES-1 and counts down to 0, so the
    // hold window spans exactly HOLD_CYCLES cycles and never wraps.
    localparam int unsigned    CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]     ID_IDLE  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic [2:0]       ack_d;
    logic [3:0]       lcd_d;
    logic             busy_d;
    logic [1:0]       grant_d;

    logic             win_vld;
    logic [1:0]       win_id;
    logic [3:0]       win_msg;

    // ------------------------------------------------------------------
    // Round-robin pick: search starts one past the previous winner and
    // wraps, so no requester wins twice in a row while another waits.
    // last_q only ever holds 0..2; the default arm covers last = 2.
    // ------------------------------------------------------------------
    always_comb begin
        win_vld = |req;
        win_id  = 2'd0;
        case (last_q)
            2'd0: begin
                if (req[1])      win_id = 2'd1;
                else if (req[2]) win_id = 2'd2;
                else             win_id = 2'd0;
            end
            2'd1: begin
                if (req[2])      win_id = 2'd2;
                else if (req[0]) win_id = 2'd0;
                else             win_id = 2'd1;
            end
            default: begin
                if (req[0])      win_id = 2'd0;
                else if (req[1]) win_id = 2'd1;
                else             win_id = 2'd2;
            end
        endcase
    end

    always_comb begin
        win_msg = req_msg[3:0];
        case (win_id)
            2'd0:    win_msg = req_msg[3:0];
            2'd1:    win_msg = req_msg[7:4];
            default: win_msg = req_msg[11:8];
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Outputs are computed here and
    // registered below, so nothing on the ports is combinational from req.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ack_d   = 3'b000;
        lcd_d   = lcd_char_array;
        busy_d  = busy;
        grant_d = grant_id;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LOAD;
                    last_d  = win_id;
                    ack_d   = 3'b001 << win_id;
                    lcd_d   = win_msg;
                    busy_d  = 1'b1;
                    grant_d = win_id;
                end
            end

            HOLD: begin
                // req and req_msg are deliberately not looked at here: the
                // latched code must stay put for the whole window.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    grant_d = ID_IDLE;
                    if (!STICKY) begin
                        lcd_d = DEFAULT_MSG;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                grant_d = ID_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Reset is asynchronous: a reset in the
    // middle of a hold drops the grant and the outputs at once.
    // last_q resets to 2 so the first search order is 0, 1, 2.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_q         <= 2'd2;
            ack            <= 3'b000;
            lcd_char_array <= DEFAULT_MSG;
            busy           <= 1'b0;
            grant_id       <= ID_IDLE;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_q         <= last_d;
            ack            <= ack_d;
            lcd_char_array <= lcd_d;
            busy           <= busy_d;
            grant_id       <= grant_d;
        end
    end

endmodule

// File: tb/tb_lcd_message_arbiter.sv
// Purpose: self-checking bench for lcd_message_arbiter (sticky and non-sticky copies driven in parallel).
// Latency: expected outputs are derived from grant times; each cycle is compared 3 time units after the clock edge.
// Backpressure: requesters drop req in the ack cycle unless a test holds it high on purpose.

module tb_lcd_message_arbiter;

    localparam int         HOLD = 4;
    localparam logic [3:0] DEF  = 4'd0;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] req_msg;

    logic [2:0]  ack,  ack_ns;
    logic [3:0]  lcd,  lcd_ns;
    logic        busy, busy_ns;
    logic [1:0]  gid,  gid_ns;

    int tests = 0;
    int fails = 0;

    lcd_message_arbiter #(.HOLD_CYCLES(HOLD), .DEFAULT_MSG(DEF), .STICKY(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_msg(req_msg),
        .ack(ack), .lcd_char_array(lcd), .busy(busy), .grant_id(gid)
    );

    lcd_message_arbiter #(.HOLD_CYCLES(HOLD), .DEFAULT_MSG(DEF), .STICKY(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req(req), .req_msg(req_msg),
        .ack(ack_ns), .lcd_char_array(lcd_ns), .busy(busy_ns), .grant_id(gid_ns)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: remembers only when the last grant happened, who won and the
    // code. A cycle is inside the hold window while fewer than HOLD cycles
    // have elapsed since the grant; a new grant is possible only at an edge
    // that closes a cycle outside any window.
    // ------------------------------------------------------------------
    int         m_cyc;
    int         m_gcyc;
    int         m_owner;
    int         m_last;
    logic [3:0] m_code;

    task automatic m_reset();
        m_cyc   = 0;
        m_gcyc  = -1000;
        m_owner = 3;
        m_last  = 2;
        m_code  = DEF;
    endtask

    task automatic m_step();
        int  prev;
        int  w;
        bit  found;
        prev  = m_cyc;
        m_cyc = prev + 1;
        found = 1'b0;
        w     = 0;
        if ((prev - m_gcyc) >= HOLD && req != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                if (!found && req[(m_last + k) % 3]) begin
                    w     = (m_last + k) % 3;
                    found = 1'b1;
                end
            end
            m_gcyc  = m_cyc;
            m_owner = w;
            m_last  = w;
            m_code  = req_msg[4*w +: 4];
        end
    endtask

    initial begin
        logic [2:0] e_ack;
        logic       e_busy;
        logic [1:0] e_gid;
        logic [3:0] e_lcd, e_lcd_ns;
        int         d;
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else     m_step();
            #3;
            if (rst) begin
                e_ack = 3'b000; e_busy = 1'b0; e_gid = 2'd3; e_lcd = DEF; e_lcd_ns = DEF;
            end else begin
                d        = m_cyc - m_gcyc;
                e_busy   = (d < HOLD);
                e_ack    = (d == 0) ? 3'(3'b001 << m_owner) : 3'b000;
                e_gid    = e_busy ? 2'(m_owner) : 2'd3;
                e_lcd    = m_code;
                e_lcd_ns = e_busy ? m_code : DEF;
            end
            check("cyc_ack",     32'(ack),     32'(e_ack));
            check("cyc_busy",    32'(busy),    32'(e_busy));
            check("cyc_gid",     32'(gid),     32'(e_gid));
            check("cyc_lcd",     32'(lcd),     32'(e_lcd));
            check("cyc_ack_ns",  32'(ack_ns),  32'(e_ack));
            check("cyc_busy_ns", 32'(busy_ns), 32'(e_busy));
            check("cyc_gid_ns",  32'(gid_ns),  32'(e_gid));
            check("cyc_lcd_ns",  32'(lcd_ns),  32'(e_lcd_ns));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed literal expectations.
    // ------------------------------------------------------------------
    bit         auto_drop;
    int         cyc_tb;
    int         ngr;
    int         g_id   [8];
    int         g_cyc  [8];
    logic [3:0] g_code [8];

    task automatic step();
        @(negedge clk);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic run_log(input int n);
        repeat (n) begin
            step();
            cyc_tb++;
            if (ack != 3'b000 && ngr < 8) begin
                g_id[ngr]   = ack[0] ? 0 : (ack[1] ? 1 : 2);
                g_cyc[ngr]  = cyc_tb;
                g_code[ngr] = lcd;
                ngr++;
            end
        end
    endtask

    initial begin
        int bad;
        int nb;
        int na;
        rst = 1'b0; req = 3'b000; req_msg = 12'h000;
        auto_drop = 1'b1; cyc_tb = 0; ngr = 0;

        // Reset asserted mid-cycle: outputs take reset values at once.
        #2 rst = 1'b1;
        #1;
        check("rst_lcd",  32'(lcd),  32'h0);
        check("rst_gid",  32'(gid),  32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ack",  32'(ack),  32'h0);
        step(); step();
        rst = 1'b0;

        // No requests: nothing moves for 20 cycles.
        bad = 0;
        repeat (20) begin
            step();
            if (lcd !== 4'h0 || gid !== 2'd3 || busy !== 1'b0 || ack !== 3'b000) bad++;
        end
        check("idle_quiet_cycles", 32'(bad), 32'h0);

        // Single request from requester 1 with code 5.
        req = 3'b010; req_msg = 12'h050;
        step();
        check("single_ack",  32'(ack),  32'h2);
        check("single_lcd",  32'(lcd),  32'h5);
        check("single_gid",  32'(gid),  32'h1);
        check("single_busy", 32'(busy), 32'h1);
        nb = 1; na = 1;
        repeat (7) begin
            step();
            if (busy) nb++;
            if (ack != 3'b000) na++;
        end
        check("single_busy_len",   32'(nb),   32'h4);
        check("single_ack_count",  32'(na),   32'h1);
        check("single_after_lcd",  32'(lcd),  32'h5);
        check("single_after_gid",  32'(gid),  32'h3);
        check("single_after_busy", 32'(busy), 32'h0);

        // Non-sticky copy: code A for 4 cycles, then default in first idle cycle.
        req = 3'b100; req_msg = 12'hA00;
        step();
        check("ns_ack",     32'(ack_ns), 32'h4);
        check("ns_lcd_on",  32'(lcd_ns), 32'hA);
        repeat (3) step();
        check("ns_lcd_last_hold", 32'(lcd_ns),  32'hA);
        step();
        check("ns_lcd_idle",   32'(lcd_ns),  32'h0);
        check("ns_busy_idle",  32'(busy_ns), 32'h0);
        check("sticky_lcd_idle", 32'(lcd),   32'hA);

        // Round-robin: all three pending, codes 1/2/3.
        req = 3'b111; req_msg = 12'h321; ngr = 0;
        run_log(16);
        check("rr_count",   32'(ngr),       32'd3);
        check("rr_first",   32'(g_id[0]),   32'd0);
        check("rr_second",  32'(g_id[1]),   32'd1);
        check("rr_third",   32'(g_id[2]),   32'd2);
        check("rr_code0",   32'(g_code[0]), 32'h1);
        check("rr_code1",   32'(g_code[1]), 32'h2);
        check("rr_code2",   32'(g_code[2]), 32'h3);
        check("rr_space01", 32'(g_cyc[1] - g_cyc[0]), 32'd5);
        check("rr_space12", 32'(g_cyc[2] - g_cyc[1]), 32'd5);

        // Again all three: order restarts at requester 0.
        req = 3'b111; ngr = 0;
        run_log(2);
        check("rr2_first", 32'(g_id[0]), 32'd0);
        run_log(14);
        check("rr2_count", 32'(ngr),       32'd3);
        check("rr2_last",  32'(g_id[2]),   32'd2);

        // Mid-hold code change is ignored.
        req = 3'b001; req_msg = 12'h007;
        step();
        check("hold_grant_lcd", 32'(lcd), 32'h7);
        req_msg = 12'h009;
        repeat (3) begin
            step();
            check("hold_lcd_stable", 32'(lcd), 32'h7);
        end
        step();
        check("hold_end_busy", 32'(busy), 32'h0);
        check("hold_end_lcd",  32'(lcd),  32'h7);

        // Reset in hold cycle 2 with req left high.
        auto_drop = 1'b0;
        req = 3'b001; req_msg = 12'h004;
        step();
        check("rh_grant_lcd", 32'(lcd), 32'h4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rh_lcd",  32'(lcd),  32'h0);
        check("rh_gid",  32'(gid),  32'h3);
        check("rh_busy", 32'(busy), 32'h0);
        check("rh_ack",  32'(ack),  32'h0);
        step(); step();
        rst = 1'b0;
        auto_drop = 1'b1;
        step();
        check("rh_regrant_ack", 32'(ack), 32'h1);
        check("rh_regrant_lcd", 32'(lcd), 32'h4);
        check("rh_regrant_gid", 32'(gid), 32'h0);
        na = 1;
        repeat (6) begin
            step();
            if (ack != 3'b000) na++;
        end
        check("rh_ack_count", 32'(na), 32'h1);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
